serial_alu_n: RTL and testbench

Parametrised digit-serial ALU. It is the successor of the fixed 8-bit, 2-bit-per-cycle core ALU, generalised to any digit width and to operands of 1..MAX_WORDS words. Operand digits arrive LSB-first from an external register-file scan or memory interface. Result digits leave on the same cycle, and the block keeps its own C/V/S/Z flags. New versus the current core: explicit start/busy/done handshake, variable operand length, arg2 narrower than arg1 with zero or sign fill, and a compare mode with write suppression.

---
 rtl/serial_alu_n.sv | 207 ++++++++++++++++++++
 tb/tb_serial_alu_n.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_alu_n.sv
`default_nettype none
// ============================================================================
// Module      : serial_alu_n
// Description : Digit-serial ALU, LSB-first, 1..MAX_WORDS words per operand,
//               with start/busy/done handshake and its own C/V/S/Z flags.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_alu_n #(
  parameter int REG_BITS  = 8,
  parameter int NSHIFT    = 2,
  parameter int MAX_WORDS = 4,
  parameter int WB        = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1,
  parameter int CB        = ((MAX_WORDS * REG_BITS / NSHIFT) > 1) ?
                            $clog2(MAX_WORDS * REG_BITS / NSHIFT) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        operation,
  input  logic              compare,
  input  logic [WB-1:0]     words_m1,
  input  logic [WB-1:0]     arg2_words_m1,
  input  logic              sext2,
  input  logic              double_arg2,
  input  logic              advance,
  input  logic [NSHIFT-1:0] data_in1,
  input  logic [NSHIFT-1:0] data_in2,
  output logic [NSHIFT-1:0] data_out,
  output logic              write_en,
  output logic              busy,
  output logic              op_done,
  output logic [CB-1:0]     counter,
  input  logic              flag_load,
  input  logic [3:0]        flags_in,
  output logic              flag_c,
  output logic              flag_v,
  output logic              flag_s,
  output logic              flag_z
);

  localparam int         c_dpw    = REG_BITS / NSHIFT;
  localparam logic [2:0] c_op_add = 3'd0;
  localparam logic [2:0] c_op_sub = 3'd1;
  localparam logic [2:0] c_op_and = 3'd4;
  localparam logic [2:0] c_op_or  = 3'd5;
  localparam logic [2:0] c_op_xor = 3'd6;

  logic [2:0]        r_op;
  logic              r_cmp;
  logic [WB-1:0]     r_words_m1;
  logic [WB-1:0]     r_a2w_m1;
  logic              r_sext2;
  logic              r_dbl;
  logic              r_busy;
  logic [CB-1:0]     r_counter;
  logic              r_carry;
  logic              r_sign2;
  logic              r_zrun;
  logic              r_prev_msb;
  logic              r_fc, r_fv, r_fs, r_fz;

  logic [31:0]       w_nlast;
  logic [31:0]       w_n2;
  logic              w_last;
  logic              w_in2;
  logic              w_sign_cap;
  logic              w_step;
  logic              w_done;
  logic              w_accept;
  logic [WB-1:0]     w_a2w_clip;
  logic [NSHIFT-1:0] w_ext;
  logic [NSHIFT-1:0] w_d2;
  logic [NSHIFT-1:0] w_b;
  logic              w_arith;
  logic              w_cin0;
  logic              w_cin;
  logic [NSHIFT:0]   w_sum;
  logic [NSHIFT-1:0] w_res;
  logic              w_v;
  logic              w_z;

  assign w_nlast    = (32'(r_words_m1) + 32'd1) * 32'(c_dpw) - 32'd1;
  assign w_n2       = (32'(r_a2w_m1) + 32'd1) * 32'(c_dpw);
  assign w_last     = (32'(r_counter) == w_nlast);
  assign w_in2      = (32'(r_counter) < w_n2);
  assign w_sign_cap = (32'(r_counter) == (w_n2 - 32'd1));
  assign w_step     = r_busy & advance;
  assign w_done     = w_step & w_last;
  assign w_accept   = start & (~r_busy | w_done);
  assign w_a2w_clip = (arg2_words_m1 > words_m1) ? words_m1 : arg2_words_m1;

  // Beyond its valid length arg2 reads as all-zero or all-sign digits
  assign w_ext = w_in2 ? data_in2 : {NSHIFT{r_sext2 & r_sign2}};

  generate
    if (NSHIFT > 1) begin : g_dbl_wide
      assign w_d2 = r_dbl ? {w_ext[NSHIFT-2:0], r_prev_msb} : w_ext;
    end else begin : g_dbl_bit
      assign w_d2 = r_dbl ? r_prev_msb : w_ext;
    end
  endgenerate

  assign w_arith = ~r_op[2];
  assign w_b     = (w_arith & r_op[0]) ? ~w_d2 : w_d2;

  always_comb begin
    w_cin0 = 1'b0;
    case (r_op)
      c_op_add: w_cin0 = 1'b0;
      c_op_sub: w_cin0 = 1'b1;
      3'd2,
      3'd3:     w_cin0 = r_fc;
      default:  w_cin0 = 1'b0;
    endcase
  end

  assign w_cin = (r_counter == '0) ? w_cin0 : r_carry;
  assign w_sum = {1'b0, data_in1} + {1'b0, w_b} + {{NSHIFT{1'b0}}, w_cin};

  always_comb begin
    w_res = w_sum[NSHIFT-1:0];
    case (r_op)
      c_op_and: w_res = data_in1 & w_d2;
      c_op_or:  w_res = data_in1 | w_d2;
      c_op_xor: w_res = data_in1 ^ w_d2;
      3'd7:     w_res = w_d2;
      default:  w_res = w_sum[NSHIFT-1:0];
    endcase
  end

  assign w_v = (data_in1[NSHIFT-1] == w_b[NSHIFT-1]) &&
               (w_res[NSHIFT-1] != data_in1[NSHIFT-1]);
  assign w_z = ((r_counter == '0) ? 1'b1 : r_zrun) & (w_res == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op       <= '0;
      r_cmp      <= 1'b0;
      r_words_m1 <= '0;
      r_a2w_m1   <= '0;
      r_sext2    <= 1'b0;
      r_dbl      <= 1'b0;
      r_busy     <= 1'b0;
      r_counter  <= '0;
      r_carry    <= 1'b0;
      r_sign2    <= 1'b0;
      r_zrun     <= 1'b0;
      r_prev_msb <= 1'b0;
      r_fc       <= 1'b0;
      r_fv       <= 1'b0;
      r_fs       <= 1'b0;
      r_fz       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op       <= operation;
        r_cmp      <= compare;
        r_words_m1 <= words_m1;
        r_a2w_m1   <= w_a2w_clip;
        r_sext2    <= sext2;
        r_dbl      <= double_arg2;
        r_busy     <= 1'b1;
        r_counter  <= '0;
        r_carry    <= 1'b0;
        r_sign2    <= 1'b0;
        r_zrun     <= 1'b1;
        r_prev_msb <= 1'b0;
      end else if (w_step) begin
        if (w_last) begin
          r_busy    <= 1'b0;
          r_counter <= '0;
        end else begin
          r_counter <= r_counter + CB'(1);
        end
        r_carry    <= w_sum[NSHIFT];
        r_zrun     <= w_z;
        r_prev_msb <= w_ext[NSHIFT-1];
        if (w_sign_cap) begin
          r_sign2 <= data_in2[NSHIFT-1];
        end
      end

      // The completing operation's flags take priority over an external load
      if (w_done) begin
        r_fs <= w_res[NSHIFT-1];
        r_fz <= w_z;
        if (w_arith) begin
          r_fc <= w_sum[NSHIFT];
          r_fv <= w_v;
        end
      end else if (flag_load && !r_busy) begin
        {r_fc, r_fv, r_fs, r_fz} <= flags_in;
      end
    end
  end

  assign data_out = w_res;
  assign write_en = w_step & ~r_cmp;
  assign busy     = r_busy;
  assign op_done  = w_done;
  assign counter  = r_counter;
  assign flag_c   = r_fc;
  assign flag_v   = r_fv;
  assign flag_s   = r_fs;
  assign flag_z   = r_fz;

endmodule
`default_nettype wire

// File: tb/tb_serial_alu_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_alu_n
// Description : Self-checking bench for serial_alu_n against a word-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_alu_n;

  localparam int RB  = 8;
  localparam int NS  = 2;
  localparam int MW  = 4;
  localparam int WB  = (MW > 1) ? $clog2(MW) : 1;
  localparam int CB  = ((MW * RB / NS) > 1) ? $clog2(MW * RB / NS) : 1;
  localparam int DPW = RB / NS;

  logic          clk;
  logic          reset;
  logic          start;
  logic [2:0]    operation;
  logic          compare;
  logic [WB-1:0] words_m1;
  logic [WB-1:0] arg2_words_m1;
  logic          sext2;
  logic          double_arg2;
  logic          advance;
  logic [NS-1:0] data_in1;
  logic [NS-1:0] data_in2;
  logic [NS-1:0] data_out;
  logic          write_en;
  logic          busy;
  logic          op_done;
  logic [CB-1:0] counter;
  logic          flag_load;
  logic [3:0]    flags_in;
  logic          flag_c, flag_v, flag_s, flag_z;

  serial_alu_n #(
    .REG_BITS(RB), .NSHIFT(NS), .MAX_WORDS(MW), .WB(WB), .CB(CB)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .operation(operation),
    .compare(compare), .words_m1(words_m1), .arg2_words_m1(arg2_words_m1),
    .sext2(sext2), .double_arg2(double_arg2), .advance(advance),
    .data_in1(data_in1), .data_in2(data_in2), .data_out(data_out),
    .write_en(write_en), .busy(busy), .op_done(op_done), .counter(counter),
    .flag_load(flag_load), .flags_in(flags_in),
    .flag_c(flag_c), .flag_v(flag_v), .flag_s(flag_s), .flag_z(flag_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    bit          cmp;
    int          wm1;
    int          w2m1;
    bit          sx;
    bit          db;
    logic [63:0] a;
    logic [63:0] b;
  } cfg_t;

  int n_cmp = 0;
  int n_err = 0;
  bit m_c, m_v, m_s, m_z;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic cfg_t mk(input logic [2:0] op, input bit cmp, input int wm1,
                              input int w2m1, input bit sx, input bit db,
                              input logic [63:0] a, input logic [63:0] b);
    cfg_t c;
    c.op = op; c.cmp = cmp; c.wm1 = wm1; c.w2m1 = w2m1;
    c.sx = sx; c.db = db; c.a = a; c.b = b;
    return c;
  endfunction

  function automatic logic [63:0] mask(input int n);
    return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
  endfunction

  function automatic int clip2(input cfg_t c);
    return (c.w2m1 < c.wm1) ? c.w2m1 : c.wm1;
  endfunction

  // Whole-operand reference: extend/double arg2 as an integer, then one add or bitwise op
  task automatic model(input cfg_t c, output logic [63:0] res);
    int          L, w2;
    logic [63:0] a, bv, bb, ml;
    logic [64:0] full;
    bit          cin;
    L  = (c.wm1 + 1) * RB;
    w2 = (clip2(c) + 1) * RB;
    ml = mask(L);
    a  = c.a & ml;
    bv = c.b & mask(w2);
    if (c.sx && bv[w2-1]) bv = bv | ~mask(w2);
    bv = bv & ml;
    if (c.db) bv = (bv << 1) & ml;
    res = '0;
    case (c.op)
      3'd0, 3'd1, 3'd2, 3'd3: begin
        bb   = c.op[0] ? (~bv & ml) : bv;
        cin  = (c.op == 3'd0) ? 1'b0 : (c.op == 3'd1) ? 1'b1 : m_c;
        full = {1'b0, a} + {1'b0, bb} + 65'(cin);
        res  = full[63:0] & ml;
        m_c  = full[L];
        m_v  = (a[L-1] == bb[L-1]) && (res[L-1] != a[L-1]);
      end
      3'd4: res = a & bv;
      3'd5: res = a | bv;
      3'd6: res = a ^ bv;
      default: res = bv;
    endcase
    m_s = res[L-1];
    m_z = (res == 64'd0);
  endtask

  task automatic apply_cfg(input cfg_t c);
    operation     = c.op;
    compare       = c.cmp;
    words_m1      = WB'(c.wm1);
    arg2_words_m1 = WB'(c.w2m1);
    sext2         = c.sx;
    double_arg2   = c.db;
  endtask

  task automatic start_op(input cfg_t c, input bit fl, input logic [3:0] fin);
    @(negedge clk);
    apply_cfg(c);
    start = 1'b1; flag_load = fl; flags_in = fin; advance = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; flag_load = 1'b0;
    if (fl) {m_c, m_v, m_s, m_z} = fin;
    check("busy_after_start", busy, 1);
    check("counter_at_start", counter, 0);
  endtask

  task automatic run_digits(input cfg_t c, input int stall_at, input int stop_at,
                            input bit chain, input cfg_t nxt, output logic [63:0] got);
    int          n, n2;
    logic [63:0] exp;
    n   = (c.wm1 + 1) * DPW;
    n2  = (clip2(c) + 1) * DPW;
    got = '0;
    model(c, exp);
    for (int i = 0; i < n; i++) begin
      if (i == stop_at) return;
      if (i == stall_at) begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          advance = 1'b0; data_in1 = NS'($urandom); data_in2 = NS'($urandom);
          #1;
          check("stall_write_en", write_en, 0);
          check("stall_counter", counter, i);
        end
      end
      @(negedge clk);
      advance  = 1'b1;
      data_in1 = NS'(c.a >> (i * NS));
      data_in2 = (i < n2) ? NS'(c.b >> (i * NS)) : NS'($urandom);
      if (chain && i == n - 1) begin
        apply_cfg(nxt);
        start = 1'b1;
      end
      #1;
      got = got | (64'(data_out) << (i * NS));
      check("write_en", write_en, !c.cmp);
      check("op_done", op_done, i == n - 1);
      check("counter", counter, i);
      @(posedge clk); #1;
      advance = 1'b0; start = 1'b0;
    end
    check("result", got, exp);
    check("flags_cvsz", {flag_c, flag_v, flag_s, flag_z}, {m_c, m_v, m_s, m_z});
    check("busy_after_done", busy, chain);
    check("counter_wrap", counter, 0);
  endtask

  initial begin
    cfg_t        c, c2;
    logic [63:0] got;
    reset = 1'b1; start = 1'b0; operation = '0; compare = 1'b0;
    words_m1 = '0; arg2_words_m1 = '0; sext2 = 1'b0; double_arg2 = 1'b0;
    advance = 1'b0; data_in1 = '0; data_in2 = '0; flag_load = 1'b0; flags_in = '0;
    m_c = 0; m_v = 0; m_s = 0; m_z = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_counter", counter, 0);
    check("reset_flags", {flag_c, flag_v, flag_s, flag_z}, 4'b0000);
    @(negedge clk); reset = 1'b0;

    c = mk(3'd0, 0, 1, 1, 0, 0, 64'h12FF, 64'h0001);
    start_op(c, 0, 4'h0); run_digits(c, -1, -1, 0, c, got);
    check("add16", got, 64'h1300);
    check("add16_flags", {flag_c, flag_v, flag_s, flag_z}, 4'b0000);

    c = mk(3'd1, 0, 0, 0, 0, 0, 64'h00, 64'h01);
    start_op(c, 0, 4'h0); run_digits(c, -1, -1, 0, c, got);
    check("sub_0_1", got, 64'hFF);
    check("sub_0_1_flags", {flag_c, flag_v, flag_s, flag_z}, 4'b0010);

    c = mk(3'd1, 0, 0, 0, 0, 0, 64'h80, 64'h01);
    start_op(c, 0, 4'h0); run_digits(c, -1, -1, 0, c, got);
    check("sub_80_1", got, 64'h7F);
    check("sub_80_1_flags", {flag_c, flag_v, flag_s, flag_z}, 4'b1100);

    c = mk(3'd1, 1, 0, 0, 0, 0, 64'h05, 64'h05);
    start_op(c, 0, 4'h0); run_digits(c, -1, -1, 0, c, got);
    check("cmp_flags", {flag_c, flag_v, flag_s, flag_z}, 4'b1001);

    c = mk(3'd0, 0, 1, 0, 1, 0, 64'h1000, 64'h0080);
    start_op(c, 0, 4'h0); run_digits(c, -1, -1, 0, c, got);
    check("add_sext", got, 64'h0F80);
    c = mk(3'd0, 0, 1, 0, 0, 0, 64'h1000, 64'h0080);
    start_op(c, 0, 4'h0); run_digits(c, -1, -1, 0, c, got);
    check("add_zext", got, 64'h1080);

    c = mk(3'd7, 0, 1, 1, 0, 1, 64'hABCD, 64'h0081);
    start_op(c, 0, 4'h0); run_digits(c, -1, -1, 0, c, got);
    check("mov_double", got, 64'h0102);

    c = mk(3'd2, 0, 0, 0, 0, 0, 64'h01, 64'h01);
    start_op(c, 1, 4'b1000); run_digits(c, -1, -1, 0, c, got);
    check("adc_loaded_c", got, 64'h03);
    check("adc_c_out", flag_c, 0);

    c  = mk(3'd0, 0, 0, 0, 0, 0, 64'hFF, 64'h01);
    c2 = mk(3'd2, 0, 0, 0, 0, 0, 64'h00, 64'h00);
    start_op(c, 0, 4'h0); run_digits(c, -1, -1, 1, c2, got);
    check("chain_first", got, 64'h00);
    run_digits(c2, -1, -1, 0, c2, got);
    check("chain_adc", got, 64'h01);

    c = mk(3'd0, 0, 1, 1, 0, 0, 64'h12FF, 64'h0001);
    start_op(c, 0, 4'h0); run_digits(c, 3, -1, 0, c, got);
    check("stall_add16", got, 64'h1300);

    start_op(c, 0, 4'h0); run_digits(c, -1, 3, 0, c, got);
    @(negedge clk);
    reset = 1'b1; advance = 1'b1; data_in1 = '1; data_in2 = '1;
    @(posedge clk); #1;
    check("abort_busy", busy, 0);
    check("abort_counter", counter, 0);
    check("abort_flags", {flag_c, flag_v, flag_s, flag_z}, 4'b0000);
    m_c = 0; m_v = 0; m_s = 0; m_z = 0;
    @(negedge clk); reset = 1'b0; advance = 1'b0;
    start_op(c, 0, 4'h0); run_digits(c, -1, -1, 0, c, got);
    check("after_abort", got, 64'h1300);

    for (int t = 0; t < 60; t++) begin
      c = mk(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, MW - 1)), int'($urandom_range(0, MW - 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             {$urandom, $urandom}, {$urandom, $urandom});
      start_op(c, ($urandom_range(0, 3) == 0), 4'($urandom));
      run_digits(c, int'($urandom_range(0, 12)), -1, 0, c, got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
